// File: rtl/traffic_light_ctrl.sv
// Two-road (main/side) traffic signal controller: timed phases with all-red
// clearance, demand-driven side service and a flashing night mode.
module traffic_light_ctrl #(
  parameter int CNT_W        = 7,
  parameter int MAIN_MIN_CYC = 20,
  parameter int SIDE_GRN_CYC = 10,
  parameter int YELLOW_CYC   = 4,
  parameter int ALL_RED_CYC  = 2,
  parameter int FLASH_CYC    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             side_req,
  input  logic             night_mode,
  output logic             main_signal_red,
  output logic             main_signal_yellow,
  output logic             main_signal_green,
  output logic             side_signal_red,
  output logic             side_signal_yellow,
  output logic             side_signal_green,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] count_remaining
);

  typedef enum logic [2:0] {
    MAIN_GRN = 3'd0,
    MAIN_YEL = 3'd1,
    ALL_RED1 = 3'd2,
    SIDE_GRN = 3'd3,
    SIDE_YEL = 3'd4,
    ALL_RED2 = 3'd5,
    FLASH    = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'sd1);
  localparam logic [CNT_W-1:0] MAIN_LOAD  = CNT_W'(MAIN_MIN_CYC - 32'sd1);
  localparam logic [CNT_W-1:0] SIDE_LOAD  = CNT_W'(SIDE_GRN_CYC - 32'sd1);
  localparam logic [CNT_W-1:0] YEL_LOAD   = CNT_W'(YELLOW_CYC - 32'sd1);
  localparam logic [CNT_W-1:0] AR_LOAD    = CNT_W'(ALL_RED_CYC - 32'sd1);
  localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_CYC - 32'sd1);

  // Lamp vector order: {main red, main yellow, main green, side red, side yellow, side green}
  localparam logic [5:0] LAMPS_ALL_RED = 6'b100_100;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             toggle;
  logic             toggle_next;
  logic             req_latch;
  logic             req_latch_next;
  logic             night_pend;
  logic             night_pend_next;
  logic [5:0]       lamps;

  function automatic logic [5:0] lamp_decode(input state_t s, input logic t);
    logic [5:0] l;
    case (s)
      MAIN_GRN: l = 6'b001_100;
      MAIN_YEL: l = 6'b010_100;
      SIDE_GRN: l = 6'b100_001;
      SIDE_YEL: l = 6'b100_010;
      ALL_RED1: l = LAMPS_ALL_RED;
      ALL_RED2: l = LAMPS_ALL_RED;
      FLASH:    l = {1'b0, t, 1'b0, t, 2'b00};
      default:  l = LAMPS_ALL_RED;
    endcase
    return l;
  endfunction

  // Next-state, countdown, sensor latch and pending-night logic.
  always_comb begin
    state_next      = state;
    count_next      = (count != CNT_ZERO) ? (count - CNT_ONE) : CNT_ZERO;
    toggle_next     = toggle;
    req_latch_next  = req_latch | (side_req & (state != SIDE_GRN));
    night_pend_next = night_pend;
    case (state)
      MAIN_GRN: begin
        if (count != CNT_ZERO) begin
          state_next = MAIN_GRN;
        end else if (night_mode) begin
          // Night takes priority over a waiting side-road vehicle.
          state_next      = MAIN_YEL;
          count_next      = YEL_LOAD;
          night_pend_next = 1'b1;
        end else if (req_latch) begin
          state_next = MAIN_YEL;
          count_next = YEL_LOAD;
        end else begin
          state_next = MAIN_GRN;
        end
      end
      MAIN_YEL: begin
        if (count == CNT_ZERO) begin
          state_next = ALL_RED1;
          count_next = AR_LOAD;
        end else begin
          state_next = MAIN_YEL;
        end
      end
      ALL_RED1: begin
        if (count == CNT_ZERO) begin
          if (night_pend) begin
            state_next      = FLASH;
            count_next      = FLASH_LOAD;
            toggle_next     = 1'b1;
            night_pend_next = 1'b0;
          end else begin
            state_next     = SIDE_GRN;
            count_next     = SIDE_LOAD;
            req_latch_next = 1'b0;
          end
        end else begin
          state_next = ALL_RED1;
        end
      end
      SIDE_GRN: begin
        if (count == CNT_ZERO) begin
          state_next = SIDE_YEL;
          count_next = YEL_LOAD;
        end else begin
          state_next = SIDE_GRN;
        end
      end
      SIDE_YEL: begin
        if (count == CNT_ZERO) begin
          state_next = ALL_RED2;
          count_next = AR_LOAD;
        end else begin
          state_next = SIDE_YEL;
        end
      end
      ALL_RED2: begin
        if (count == CNT_ZERO) begin
          state_next = MAIN_GRN;
          count_next = MAIN_LOAD;
        end else begin
          state_next = ALL_RED2;
        end
      end
      FLASH: begin
        if (!night_mode) begin
          state_next = ALL_RED2;
          count_next = AR_LOAD;
        end else if (count == CNT_ZERO) begin
          count_next  = FLASH_LOAD;
          toggle_next = ~toggle;
        end else begin
          state_next = FLASH;
        end
      end
      default: begin
        state_next  = ALL_RED2;
        count_next  = AR_LOAD;
        toggle_next = 1'b0;
      end
    endcase
  end

  // State/counter registers; lamps are decoded from the next state so they line up with phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ALL_RED2;
      count      <= AR_LOAD;
      toggle     <= 1'b0;
      req_latch  <= 1'b0;
      night_pend <= 1'b0;
      lamps      <= LAMPS_ALL_RED;
    end else begin
      state      <= state_next;
      count      <= count_next;
      toggle     <= toggle_next;
      req_latch  <= req_latch_next;
      night_pend <= night_pend_next;
      lamps      <= lamp_decode(state_next, toggle_next);
    end
  end

  assign {main_signal_red, main_signal_yellow, main_signal_green,
          side_signal_red, side_signal_yellow, side_signal_green} = lamps;
  assign phase           = state;
  assign count_remaining = count;

  a_one_lamp_per_road: assert property (@(posedge clk) disable iff (rst)
    (state != FLASH) |-> ($onehot(lamps[5:3]) && $onehot(lamps[2:0])));

  a_no_cross_conflict: assert property (@(posedge clk) disable iff (rst)
    !((lamps[4] | lamps[3]) && (lamps[1] | lamps[0])));

  a_main_green_entry: assert property (@(posedge clk) disable iff (rst)
    (lamps[3] && !$past(lamps[3])) |-> !($past(lamps[4]) || $past(lamps[1]) || $past(lamps[0])));

  a_side_green_entry: assert property (@(posedge clk) disable iff (rst)
    (lamps[0] && !$past(lamps[0])) |-> !($past(lamps[1]) || $past(lamps[4]) || $past(lamps[3])));

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: directed scenarios plus random stimulus,
// every cycle compared against a phase/elapsed-time model.
module tb_traffic_light_ctrl;

  localparam int CNT_W    = 7;
  localparam int MAIN_MIN = 8;
  localparam int SIDE_GRN = 6;
  localparam int YELLOW   = 3;
  localparam int ALL_RED  = 2;
  localparam int FLASH    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             side_req = 1'b0;
  logic             night_mode = 1'b0;
  logic             mr, my, mg, sr, sy, sg;
  logic [2:0]       phase;
  logic [CNT_W-1:0] count_remaining;
  logic [5:0]       lamps_now;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model: current phase number, cycles spent in it, latched demand, pending night
  int m_phase = 5;
  int m_el    = 0;
  bit m_req   = 1'b0;
  bit m_night = 1'b0;

  traffic_light_ctrl #(
    .CNT_W(CNT_W), .MAIN_MIN_CYC(MAIN_MIN), .SIDE_GRN_CYC(SIDE_GRN),
    .YELLOW_CYC(YELLOW), .ALL_RED_CYC(ALL_RED), .FLASH_CYC(FLASH)
  ) dut (
    .clk(clk), .rst(rst), .side_req(side_req), .night_mode(night_mode),
    .main_signal_red(mr), .main_signal_yellow(my), .main_signal_green(mg),
    .side_signal_red(sr), .side_signal_yellow(sy), .side_signal_green(sg),
    .phase(phase), .count_remaining(count_remaining)
  );

  always #5 clk = ~clk;

  assign lamps_now = {mr, my, mg, sr, sy, sg};

  function automatic int dur_of(int ph);
    int d;
    case (ph)
      0:       d = MAIN_MIN;
      1, 4:    d = YELLOW;
      2, 5:    d = ALL_RED;
      3:       d = SIDE_GRN;
      6:       d = FLASH;
      default: d = 1;
    endcase
    return d;
  endfunction

  function automatic logic [5:0] exp_lamps(int ph, int el);
    logic [5:0] l;
    case (ph)
      0:       l = 6'b001100;
      1:       l = 6'b010100;
      3:       l = 6'b100001;
      4:       l = 6'b100010;
      6:       l = (((el / FLASH) % 2) == 0) ? 6'b010100 : 6'b000000;
      default: l = 6'b100100;
    endcase
    return l;
  endfunction

  function automatic int exp_count(int ph, int el);
    int c;
    if (ph == 6) begin
      c = FLASH - 1 - (el % FLASH);
    end else begin
      c = dur_of(ph) - 1 - el;
      if (c < 0) c = 0;
    end
    return c;
  endfunction

  task automatic model_step();
    int nxt;
    bit done;
    bit req_n;
    bit night_n;
    if (rst) begin
      m_phase = 5;
      m_el    = 0;
      m_req   = 1'b0;
      m_night = 1'b0;
    end else begin
      done    = (m_el >= dur_of(m_phase) - 1);
      nxt     = m_phase;
      req_n   = m_req || (side_req && m_phase != 3);
      night_n = m_night;
      case (m_phase)
        0: begin
          if (done && night_mode) begin
            nxt = 1;
            night_n = 1'b1;
          end else if (done && m_req) begin
            nxt = 1;
          end
        end
        1: if (done) nxt = 2;
        2: if (done) nxt = m_night ? 6 : 3;
        3: if (done) nxt = 4;
        4: if (done) nxt = 5;
        5: if (done) nxt = 0;
        6: if (!night_mode) nxt = 5;
        default: nxt = 5;
      endcase
      if (nxt == 3 && m_phase != 3) req_n = 1'b0;
      if (nxt == 6 && m_phase != 6) night_n = 1'b0;
      m_el    = (nxt != m_phase) ? 0 : m_el + 1;
      m_phase = nxt;
      m_req   = req_n;
      m_night = night_n;
    end
  endtask

  task automatic model_compare();
    logic [CNT_W+8:0] got;
    logic [CNT_W+8:0] want;
    got  = {phase, count_remaining, lamps_now};
    want = {3'(m_phase), CNT_W'(exp_count(m_phase, m_el)), exp_lamps(m_phase, m_el)};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL model_cycle t=%0t: got phase=%0d count=%0d lamps=%b, want phase=%0d count=%0d lamps=%b",
               $time, phase, count_remaining, lamps_now, m_phase, exp_count(m_phase, m_el),
               exp_lamps(m_phase, m_el));
    end
  endtask

  task automatic lit(string name, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic lit_lamps(string name, logic [5:0] got, logic [5:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got lamps %b want %b", name, got, want);
    end
  endtask

  // one clock: model follows the edge, outputs are compared on the falling edge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    model_compare();
  endtask

  task automatic go_to(int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    tick();

    // idle after reset: two all-red cycles, then main green forever
    do_reset();
    lit("t1_c0_phase", int'(phase), 5);
    lit("t1_c0_count", int'(count_remaining), 1);
    lit_lamps("t1_c0_lamps", lamps_now, 6'b100100);
    go_to(1);  lit("t1_c1_count", int'(count_remaining), 0);
    go_to(2);  lit("t1_c2_phase", int'(phase), 0);
    lit("t1_c2_count", int'(count_remaining), 7);
    lit_lamps("t1_c2_lamps", lamps_now, 6'b001100);
    go_to(39); lit("t1_c39_phase", int'(phase), 0);
    lit("t1_c39_count", int'(count_remaining), 0);

    // single-cycle side request at cycle 4
    do_reset();
    go_to(4);  side_req = 1'b1;
    go_to(5);  side_req = 1'b0;
    go_to(9);  lit("t2_c9_phase", int'(phase), 0);
    go_to(10); lit("t2_c10_phase", int'(phase), 1);
    lit("t2_c10_count", int'(count_remaining), 2);
    lit_lamps("t2_c10_lamps", lamps_now, 6'b010100);
    go_to(13); lit("t2_c13_phase", int'(phase), 2);
    go_to(15); lit("t2_c15_phase", int'(phase), 3);
    lit("t2_c15_count", int'(count_remaining), 5);
    lit_lamps("t2_c15_lamps", lamps_now, 6'b100001);
    go_to(21); lit("t2_c21_phase", int'(phase), 4);
    lit_lamps("t2_c21_lamps", lamps_now, 6'b100010);
    go_to(24); lit("t2_c24_phase", int'(phase), 5);
    go_to(26); lit("t2_c26_phase", int'(phase), 0);
    lit("t2_c26_count", int'(count_remaining), 7);

    // side request held high: fixed 24-cycle rotation
    do_reset();
    side_req = 1'b1;
    go_to(33); lit("t3_c33_phase", int'(phase), 0);
    go_to(34); lit("t3_c34_phase", int'(phase), 1);
    go_to(39); lit("t3_c39_phase", int'(phase), 3);
    go_to(44); lit("t3_c44_phase", int'(phase), 3);
    go_to(45); lit("t3_c45_phase", int'(phase), 4);
    go_to(57); lit("t3_c57_phase", int'(phase), 0);
    go_to(58); lit("t3_c58_phase", int'(phase), 1);
    side_req = 1'b0;

    // night and side request together at main-green expiry, then night drops
    do_reset();
    go_to(9);  night_mode = 1'b1; side_req = 1'b1;
    go_to(10); side_req = 1'b0;
    lit("t4_c10_phase", int'(phase), 1);
    go_to(13); lit("t4_c13_phase", int'(phase), 2);
    go_to(15); lit("t4_c15_phase", int'(phase), 6);
    lit("t4_model_c15", m_phase, 6);
    lit("t4_c15_count", int'(count_remaining), 3);
    lit_lamps("t4_c15_lamps", lamps_now, 6'b010100);
    go_to(18); lit_lamps("t4_c18_lamps", lamps_now, 6'b010100);
    go_to(19); lit_lamps("t4_c19_lamps", lamps_now, 6'b000000);
    lit("t4_c19_count", int'(count_remaining), 3);
    go_to(23); lit_lamps("t4_c23_lamps", lamps_now, 6'b010100);
    go_to(25); night_mode = 1'b0;
    go_to(26); lit("t5_c26_phase", int'(phase), 5);
    lit_lamps("t5_c26_lamps", lamps_now, 6'b100100);
    go_to(28); lit("t5_c28_phase", int'(phase), 0);
    go_to(35); lit("t5_c35_phase", int'(phase), 0);
    go_to(36); lit("t5_c36_phase", int'(phase), 1);

    // reset during side green
    go_to(41); lit("t6_c41_phase", int'(phase), 3);
    go_to(43);
    do_reset();
    lit("t6_rst_phase", int'(phase), 5);
    lit("t6_rst_count", int'(count_remaining), 1);
    lit_lamps("t6_rst_lamps", lamps_now, 6'b100100);
    go_to(40); lit("t6_c40_phase", int'(phase), 0);

    // latched request discarded by a reset during main green
    do_reset();
    go_to(3);  side_req = 1'b1;
    go_to(4);  side_req = 1'b0;
    go_to(5);
    do_reset();
    go_to(40); lit("t6b_c40_phase", int'(phase), 0);

    // random traffic, night toggles and occasional resets
    for (int i = 0; i < 3000; i++) begin
      side_req = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 59) == 0) night_mode = ~night_mode;
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
